// File: rtl/ibex_pkg.sv
// Shared definitions for the dummy instruction burst inserter: FSM states,
// op-select encodings, RV32IM funct fields and LFSR field layout.
package ibex_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        INSERT = 2'd2
    } dummy_state_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_MUL = 3'd1,
        OP_DIV = 3'd2,
        OP_AND = 3'd3,
        OP_XOR = 3'd4,
        OP_OR  = 3'd5,
        OP_SUB = 3'd6,
        OP_REM = 3'd7
    } dummy_op_e;

    typedef struct packed {
        logic [6:0] funct7;
        logic [2:0] funct3;
    } dummy_funct_t;

    // Field offsets relative to the end of the threshold field (bit CntW).
    localparam int unsigned DUMMY_RS1_REL   = 0;
    localparam int unsigned DUMMY_RS2_REL   = 5;
    localparam int unsigned DUMMY_OP_REL    = 10;
    localparam int unsigned DUMMY_BURST_REL = 13;

    // Right-shifting Galois feedback mask for x^32 + x^22 + x^2 + x + 1.
    localparam logic [31:0] DUMMY_LFSR_TAPS = 32'h8020_0003;

    localparam logic [6:0] DUMMY_OPCODE_OP = 7'h33;

    // RV32IM R-type funct7/funct3 for each op select; unknown codes map to ADD.
    function automatic dummy_funct_t dummy_funct(input dummy_op_e op);
        dummy_funct_t f;
        case (op)
            OP_ADD:  f = '{funct7: 7'b000_0000, funct3: 3'b000};
            OP_MUL:  f = '{funct7: 7'b000_0001, funct3: 3'b000};
            OP_DIV:  f = '{funct7: 7'b000_0001, funct3: 3'b100};
            OP_AND:  f = '{funct7: 7'b000_0000, funct3: 3'b111};
            OP_XOR:  f = '{funct7: 7'b000_0000, funct3: 3'b100};
            OP_OR:   f = '{funct7: 7'b000_0000, funct3: 3'b110};
            OP_SUB:  f = '{funct7: 7'b010_0000, funct3: 3'b000};
            OP_REM:  f = '{funct7: 7'b000_0001, funct3: 3'b110};
            default: f = '{funct7: 7'b000_0000, funct3: 3'b000};
        endcase
        return f;
    endfunction

endpackage

// File: rtl/ibex_dummy_lfsr.sv
// 32-bit Galois LFSR with seed load (load wins over advance). A zero load
// value is replaced by 1 so the register can never lock up at zero.
module ibex_dummy_lfsr #(
    parameter logic [31:0] LfsrSeed = 32'hACE1_2345
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        seed_load_i,
    input  logic [31:0] seed_i,
    input  logic        adv_en_i,
    output logic [31:0] state_o
);
    import ibex_pkg::*;

    logic [31:0] lfsr_d;
    logic [31:0] lfsr_q;

    // Next LFSR value: reseed has priority over a single Galois step.
    always_comb begin
        lfsr_d = lfsr_q;
        if (seed_load_i) begin
            if (seed_i == 32'h0) begin
                lfsr_d = 32'h0000_0001;
            end else begin
                lfsr_d = seed_i;
            end
        end else if (adv_en_i) begin
            lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? DUMMY_LFSR_TAPS : 32'h0);
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // LFSR state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LfsrSeed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign state_o = lfsr_q;

endmodule

// File: rtl/ibex_dummy_instr_burst.sv
// Dummy instruction inserter: counts real instructions up to an LFSR-derived
// threshold, then presents a burst of random R-type dummies to ID.
module ibex_dummy_instr_burst #(
    parameter int unsigned CntW     = 5,
    parameter int unsigned MaxBurst = 4,
    parameter logic [31:0] LfsrSeed = 32'hACE1_2345
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        dummy_instr_en_i,
    input  logic [2:0]  dummy_instr_mask_i,
    input  logic        dummy_burst_en_i,
    input  logic [7:0]  dummy_op_en_i,
    input  logic        dummy_instr_seed_en_i,
    input  logic [31:0] dummy_instr_seed_i,
    input  logic        fetch_valid_i,
    input  logic        id_in_ready_i,
    output logic        insert_dummy_instr_o,
    output logic [31:0] dummy_instr_data_o,
    output logic        dummy_burst_last_o
);
    import ibex_pkg::*;

    localparam int unsigned BurstW   = (MaxBurst > 1) ? $clog2(MaxBurst) : 1;
    localparam int unsigned RemW     = $clog2(MaxBurst) + 1;
    localparam int unsigned Rs1Off   = CntW + DUMMY_RS1_REL;
    localparam int unsigned Rs2Off   = CntW + DUMMY_RS2_REL;
    localparam int unsigned OpOff    = CntW + DUMMY_OP_REL;
    localparam int unsigned BurstOff = CntW + DUMMY_BURST_REL;

    // The whole field map has to fit inside the 32-bit LFSR.
    if (CntW + 13 + $clog2(MaxBurst) > 32) begin : g_field_overflow
        $error("ibex_dummy_instr_burst: LFSR field map exceeds 32 bits");
    end

    dummy_state_e    state_d, state_q;
    logic [CntW-1:0] cnt_d, cnt_q;
    logic [RemW-1:0] burst_rem_d, burst_rem_q;
    logic [31:0]     seed_d, seed_q;
    logic [31:0]     lfsr_s;
    logic [CntW-1:0] threshold_s;
    logic [BurstW-1:0] burst_field_s;
    logic [RemW-1:0] burst_len_s;
    logic [4:0]      rs1_s, rs2_s;
    dummy_op_e       op_raw_s, op_s;
    dummy_funct_t    funct_s;
    logic            insert_s;
    logic            accept_s;
    logic            unused_lfsr_s;

    assign insert_s = (state_q == INSERT) & dummy_instr_en_i;
    assign accept_s = insert_s & id_in_ready_i;

    ibex_dummy_lfsr #(
        .LfsrSeed (LfsrSeed)
    ) u_lfsr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .seed_load_i (dummy_instr_seed_en_i),
        .seed_i      (seed_d),
        .adv_en_i    (accept_s),
        .state_o     (lfsr_s)
    );

    // Field extraction and the masked threshold come straight from the LFSR.
    assign threshold_s   = lfsr_s[CntW-1:0] & {dummy_instr_mask_i, {(CntW-3){1'b1}}};
    assign rs1_s         = lfsr_s[Rs1Off +: 5];
    assign rs2_s         = lfsr_s[Rs2Off +: 5];
    assign op_raw_s      = dummy_op_e'(lfsr_s[OpOff +: 3]);
    assign burst_field_s = lfsr_s[BurstOff +: BurstW] & BurstW'(MaxBurst - 1);
    assign unused_lfsr_s = ^lfsr_s;

    // Seed accumulator and burst length; disabled ops fall back to ADD.
    always_comb begin
        seed_d = seed_q;
        if (dummy_instr_seed_en_i) begin
            seed_d = seed_q ^ dummy_instr_seed_i;
        end else begin
            seed_d = seed_q;
        end

        burst_len_s = {RemW{1'b0}};
        if (dummy_burst_en_i) begin
            burst_len_s = RemW'(burst_field_s) + RemW'(1);
        end else begin
            burst_len_s = RemW'(1);
        end

        op_s = op_raw_s;
        if (dummy_op_en_i[op_raw_s]) begin
            op_s = op_raw_s;
        end else begin
            op_s = OP_ADD;
        end
        funct_s = dummy_funct(op_s);
    end

    // Next-state logic: disable forces IDLE from any state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        burst_rem_d = burst_rem_q;
        if (!dummy_instr_en_i) begin
            state_d     = IDLE;
            cnt_d       = {CntW{1'b0}};
            burst_rem_d = {RemW{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    cnt_d   = {CntW{1'b0}};
                end
                COUNT: begin
                    if (cnt_q == threshold_s) begin
                        state_d     = INSERT;
                        burst_rem_d = burst_len_s;
                    end else if (fetch_valid_i && id_in_ready_i) begin
                        cnt_d = cnt_q + CntW'(1);
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                INSERT: begin
                    if (id_in_ready_i) begin
                        burst_rem_d = burst_rem_q - RemW'(1);
                        if (burst_rem_q == RemW'(1)) begin
                            state_d = COUNT;
                            cnt_d   = {CntW{1'b0}};
                        end else begin
                            state_d = INSERT;
                        end
                    end else begin
                        burst_rem_d = burst_rem_q;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    cnt_d       = {CntW{1'b0}};
                    burst_rem_d = {RemW{1'b0}};
                end
            endcase
        end
    end

    // State, counter, burst and seed registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= {CntW{1'b0}};
            burst_rem_q <= {RemW{1'b0}};
            seed_q      <= 32'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            burst_rem_q <= burst_rem_d;
            seed_q      <= seed_d;
        end
    end

    // Outputs follow the enable combinationally so an abort drops them at once.
    always_comb begin
        insert_dummy_instr_o = insert_s;
        dummy_burst_last_o   = insert_s & (burst_rem_q == RemW'(1));
        if (insert_s) begin
            dummy_instr_data_o = {funct_s.funct7, rs2_s, rs1_s, funct_s.funct3,
                                  5'h00, DUMMY_OPCODE_OP};
        end else begin
            dummy_instr_data_o = 32'h0;
        end
    end

endmodule

// File: tb/tb_ibex_dummy_instr_burst.sv
// Directed bench for ibex_dummy_instr_burst with hand-computed expectations.
module tb_ibex_dummy_instr_burst;
    import ibex_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        dummy_instr_en_i;
    logic [2:0]  dummy_instr_mask_i;
    logic        dummy_burst_en_i;
    logic [7:0]  dummy_op_en_i;
    logic        dummy_instr_seed_en_i;
    logic [31:0] dummy_instr_seed_i;
    logic        fetch_valid_i;
    logic        id_in_ready_i;
    logic        insert_dummy_instr_o;
    logic [31:0] dummy_instr_data_o;
    logic        dummy_burst_last_o;

    int n_cmp = 0;
    int n_err = 0;

    ibex_dummy_instr_burst dut (
        .clk_i                 (clk_i),
        .rst_i                 (rst_i),
        .dummy_instr_en_i      (dummy_instr_en_i),
        .dummy_instr_mask_i    (dummy_instr_mask_i),
        .dummy_burst_en_i      (dummy_burst_en_i),
        .dummy_op_en_i         (dummy_op_en_i),
        .dummy_instr_seed_en_i (dummy_instr_seed_en_i),
        .dummy_instr_seed_i    (dummy_instr_seed_i),
        .fetch_valid_i         (fetch_valid_i),
        .id_in_ready_i         (id_in_ready_i),
        .insert_dummy_instr_o  (insert_dummy_instr_o),
        .dummy_instr_data_o    (dummy_instr_data_o),
        .dummy_burst_last_o    (dummy_burst_last_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i                 = 1'b1;
        dummy_instr_en_i      = 1'b0;
        dummy_instr_mask_i    = 3'b000;
        dummy_burst_en_i      = 1'b0;
        dummy_op_en_i         = 8'hFF;
        dummy_instr_seed_en_i = 1'b0;
        dummy_instr_seed_i    = 32'h0;
        fetch_valid_i         = 1'b0;
        id_in_ready_i         = 1'b0;
        tick();
        tick();
        check("rst_insert", 32'(insert_dummy_instr_o), 32'h0);
        check("rst_data",   dummy_instr_data_o,         32'h0);
        check("rst_last",   32'(dummy_burst_last_o),   32'h0);
        check("rst_lfsr",   dut.lfsr_s,                 32'hACE1_2345);
        check("rst_state",  32'(dut.state_q),          32'(IDLE));
        rst_i = 1'b0;
        tick();

        // Zero-mask back-to-back: lfsr = 0x88C42 -> thr 2, MUL x0,x2,x3, burst field 2.
        dummy_instr_seed_en_i = 1'b1;
        dummy_instr_seed_i    = 32'h0008_8C42;
        tick();
        dummy_instr_seed_en_i = 1'b0;
        check("seed_load", dut.lfsr_s, 32'h0008_8C42);
        dummy_instr_en_i = 1'b1;
        fetch_valid_i    = 1'b1;
        id_in_ready_i    = 1'b1;
        tick();
        check("b2b_entry", 32'(insert_dummy_instr_o), 32'h0);
        tick();
        check("b2b_c1",    32'(insert_dummy_instr_o), 32'h0);
        tick();
        check("b2b_c2",    32'(insert_dummy_instr_o), 32'h0);
        tick();
        check("b2b_ins1",  32'(insert_dummy_instr_o), 32'h1);
        check("b2b_data1", dummy_instr_data_o,         32'h0231_0033);
        check("b2b_last1", 32'(dummy_burst_last_o),   32'h1);
        tick();
        // Burst disabled: single dummy, LFSR stepped once to 0x44621 (thr 1).
        check("b2b_single", 32'(insert_dummy_instr_o), 32'h0);
        check("b2b_lfsr",   dut.lfsr_s,                 32'h0004_4621);
        tick();
        check("b2b_c1b",   32'(insert_dummy_instr_o), 32'h0);
        tick();
        check("b2b_ins2",  32'(insert_dummy_instr_o), 32'h1);
        check("b2b_data2", dummy_instr_data_o,         32'h0118_8033);
        check("b2b_last2", 32'(dummy_burst_last_o),   32'h1);

        // Stall for 5 cycles: everything holds.
        id_in_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_insert", 32'(insert_dummy_instr_o), 32'h1);
            check("stall_data",   dummy_instr_data_o,         32'h0118_8033);
            check("stall_lfsr",   dut.lfsr_s,                 32'h0004_4621);
            check("stall_rem",    32'(dut.burst_rem_q),      32'h1);
        end

        // Abort mid-burst: output drops in the same cycle, IDLE next cycle.
        dummy_instr_en_i = 1'b0;
        #1;
        check("abort_insert", 32'(insert_dummy_instr_o), 32'h0);
        check("abort_data",   dummy_instr_data_o,         32'h0);
        check("abort_last",   32'(dummy_burst_last_o),   32'h0);
        tick();
        check("abort_state",  32'(dut.state_q),          32'(IDLE));
        check("abort_lfsr",   dut.lfsr_s,                 32'h0004_4621);

        // Reseed with the current seed_q: XOR gives zero, LFSR loads 1.
        dummy_instr_seed_en_i = 1'b1;
        dummy_instr_seed_i    = 32'h0008_8C42;
        tick();
        dummy_instr_seed_en_i = 1'b0;
        check("reseed_zero", dut.lfsr_s, 32'h0000_0001);

        // Full burst: lfsr = 0xD18A0 -> thr 0, DIV x0,x5,x6, burst field 3.
        dummy_instr_seed_en_i = 1'b1;
        dummy_instr_seed_i    = 32'h000D_18A0;
        tick();
        dummy_instr_seed_en_i = 1'b0;
        check("burst_seed", dut.lfsr_s, 32'h000D_18A0);
        dummy_burst_en_i = 1'b1;
        dummy_instr_en_i = 1'b1;
        id_in_ready_i    = 1'b1;
        tick();
        check("burst_entry", 32'(insert_dummy_instr_o), 32'h0);
        tick();
        check("burst_ins1",  32'(insert_dummy_instr_o), 32'h1);
        check("burst_last1", 32'(dummy_burst_last_o),   32'h0);
        check("burst_data1", dummy_instr_data_o,         32'h0262_C033);
        check("burst_rem1",  32'(dut.burst_rem_q),      32'h4);

        // Only ADD enabled: same registers, funct fields forced to zero.
        dummy_op_en_i = 8'h01;
        #1;
        check("opmask_data1", dummy_instr_data_o, 32'h0062_8033);
        for (int k = 2; k <= 4; k++) begin
            tick();
            check("burst_ins",    32'(insert_dummy_instr_o), 32'h1);
            check("burst_last",   32'(dummy_burst_last_o),   (k == 4) ? 32'h1 : 32'h0);
            check("opmask_funct", 32'({dummy_instr_data_o[31:25], dummy_instr_data_o[14:12]}),
                  32'h0);
        end
        tick();
        check("burst_done_ins", 32'(insert_dummy_instr_o), 32'h0);
        check("burst_done_cnt", 32'(dut.cnt_q),           32'h0);
        check("burst_done_st",  32'(dut.state_q),         32'(COUNT));
        check("burst_lfsr4",    dut.lfsr_s,                32'h0000_D18A);

        // lfsr 0xD18A -> thr 2; reach INSERT then reset asynchronously.
        dummy_op_en_i = 8'hFF;
        tick();
        tick();
        tick();
        check("pre_rst_ins", 32'(insert_dummy_instr_o), 32'h1);
        id_in_ready_i = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        check("async_rst_ins",  32'(insert_dummy_instr_o), 32'h0);
        check("async_rst_data", dummy_instr_data_o,         32'h0);
        check("async_rst_last", 32'(dummy_burst_last_o),   32'h0);
        tick();
        rst_i            = 1'b0;
        dummy_instr_en_i = 1'b0;
        tick();
        check("post_rst_lfsr", dut.lfsr_s,                 32'hACE1_2345);
        check("post_rst_ins",  32'(insert_dummy_instr_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ibex_dummy_instr_burst.md
IBEX_DUMMY_INSTR_BURST -- requirements
Module: ibex_dummy_instr_burst

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter CntW SHALL default to 5 and set the timeout counter width (legal range 4..8).
REQ-003 Parameter MaxBurst SHALL default to 4 and set the maximum dummies per burst (power of 2, 1..16).
REQ-004 Parameter LfsrSeed SHALL default to 32'hACE1_2345 and set the LFSR reset state (must be nonzero).
REQ-005 Port clk_i, input, 1 bit: clock.
REQ-006 Port rst_i, input, 1 bit: asynchronous active-high reset.
REQ-007 Port dummy_instr_en_i, input, 1 bit: insertion enable.
REQ-008 Port dummy_instr_mask_i, input, 3 bits: masks the upper threshold bits.
REQ-009 Port dummy_burst_en_i, input, 1 bit: when 0, every burst has length 1.
REQ-010 Port dummy_op_en_i, input, 8 bits: per-opcode enable, indexed by op select.
REQ-011 Port dummy_instr_seed_en_i, input, 1 bit: reseed strobe.
REQ-012 Port dummy_instr_seed_i, input, 32 bits: reseed value.
REQ-013 Port fetch_valid_i, input, 1 bit: a real instruction is available.
REQ-014 Port id_in_ready_i, input, 1 bit: ID accepts this cycle.
REQ-015 Port insert_dummy_instr_o, output, 1 bit: a dummy is presented this cycle.
REQ-016 Port dummy_instr_data_o, output, 32 bits: dummy R-type encoding.
REQ-017 Port dummy_burst_last_o, output, 1 bit: the current dummy is the last of its burst.

Function
REQ-018 The LFSR SHALL be a 32-bit Galois LFSR (taps 32,22,2,1) that advances exactly once per accepted dummy (insert_dummy_instr_o & id_in_ready_i).
REQ-019 The LFSR field map SHALL be: [CntW-1:0] threshold seed; next 5 bits rs1; next 5 bits rs2; next 3 bits op select; next log2(MaxBurst) bits burst length.
REQ-020 The block SHALL elaborate-time assert that CntW+13+log2(MaxBurst) <= 32.
REQ-021 The block SHALL compute threshold = lfsr[CntW-1:0] & {dummy_instr_mask_i, (CntW-3) ones}.
REQ-022 On seed strobe, seed_q SHALL be updated as seed_q ^= dummy_instr_seed_i, and the LFSR SHALL load the new seed_q value.
REQ-023 If the value loaded per REQ-022 is zero, the LFSR SHALL load 32'h1 instead.
REQ-024 When a reseed coincides with an LFSR advance, the reseed SHALL win.
REQ-025 The FSM SHALL have three states: IDLE, COUNT, INSERT.
REQ-026 IDLE -> COUNT when dummy_instr_en_i = 1; on entry, cnt = 0.
REQ-027 In COUNT, cnt SHALL increment on fetch_valid_i & id_in_ready_i, wrapping modulo 2^CntW.
REQ-028 COUNT -> INSERT when cnt == threshold; on entry, burst_rem = (burst_en ? burst field : 0) + 1.
REQ-029 In INSERT, each acceptance SHALL decrement burst_rem.
REQ-030 On acceptance with burst_rem == 1, the FSM SHALL go INSERT -> COUNT with cnt = 0.
REQ-031 Without id_in_ready_i, insert_dummy_instr_o and dummy_instr_data_o SHALL hold stable.
REQ-032 Any state SHALL go -> IDLE the cycle after dummy_instr_en_i = 0.
REQ-033 insert_dummy_instr_o SHALL be (state == INSERT) & dummy_instr_en_i, so an abort mid-burst drops the output in the same cycle.
REQ-034 dummy_burst_last_o SHALL equal insert_dummy_instr_o & (burst_rem == 1).
REQ-035 Op select SHALL map: 0 ADD, 1 MUL, 2 DIV, 3 AND, 4 XOR, 5 OR, 6 SUB, 7 REM, with funct7/funct3 per RV32IM.
REQ-036 A disabled op (dummy_op_en_i bit = 0) SHALL fall back to ADD.
REQ-037 dummy_instr_data_o SHALL be {funct7, rs2, rs1, funct3, 5'h00, 7'h33} while inserting, and 0 otherwise.
REQ-038 The threshold SHALL be re-evaluated on every COUNT cycle from the current LFSR state, so a threshold of 0 permits back-to-back bursts.

Reset
REQ-039 On reset, the FSM SHALL be IDLE, cnt = 0, burst_rem = 0, seed_q = 0, lfsr = LfsrSeed, and all outputs 0.
REQ-040 Reset assertion mid-burst SHALL deassert insert_dummy_instr_o asynchronously.

Structure
REQ-041 Op select encodings, the funct7/funct3 table, and the LFSR field offsets SHALL live in ibex_pkg.
REQ-042 The LFSR SHALL be one sub-module, ibex_dummy_lfsr, with ports: seed load, advance enable, and 32-bit state out.

Verification
REQ-043 Zero-mask back-to-back: mask=000, seed giving lfsr[1:0]=2, burst_en=0, fetch_valid and ready held high -> first dummy on the 3rd cycle after COUNT entry, one dummy per burst.
REQ-044 Full burst: burst_en=1, burst field=3, MaxBurst=4 -> 4 consecutive dummies with last asserted only on the 4th, then cnt=0.
REQ-045 Stall: id_in_ready_i low for 5 cycles during INSERT -> data and insert stable; LFSR and burst_rem unchanged.
REQ-046 Op masking: dummy_op_en_i=8'h01 -> every dummy has funct7=0 and funct3=0 (ADD) regardless of op field.
REQ-047 Abort and reseed: en dropped mid-burst -> insert low the same cycle, IDLE next cycle; reseed with value equal to seed_q -> LFSR = 32'h1.
REQ-048 Reset: assert rst_i during INSERT -> all outputs 0 immediately, and LFSR = LfsrSeed after release.
